// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative M-extension unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            flush;

  modport master (
    output in_valid, funct3, rs1, rs2, out_ready, flush,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, rs1, rs2, out_ready, flush,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply, restoring divide,
// magnitude datapath with sign correction on the final iteration.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  logic            accept, sgn1, sgn2, neg1, neg2, neg_d, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    accept   = bus.in_valid && (state_q == StIdle) && !bus.flush;
    sgn1     = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn2     = bus.funct3 inside {3'b001, 3'b100, 3'b110};
    neg1     = sgn1 && bus.rs1[XLEN-1];
    neg2     = sgn2 && bus.rs2[XLEN-1];
    mag1     = neg1 ? -bus.rs1 : bus.rs1;
    mag2     = neg2 ? -bus.rs2 : bus.rs2;
    // REM/REMU follow the dividend sign; everything else negates on differing signs
    neg_d    = (bus.funct3[2] && bus.funct3[1]) ? neg1 : (neg1 ^ neg2);
    div_zero = bus.funct3[2] && (bus.rs2 == '0);
    div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.rs1 == MinNeg) && (bus.rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.funct3[1] ? bus.rs1 : '1;
    else          special_res = bus.funct3[1] ? '0 : bus.rs1;
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [XLEN:0]     sum, trial, diff;
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN-1:0]   quo, rem, final_res;
  logic              last;

  always_comb begin
    sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    trial = acc_q[2*XLEN-1:XLEN-1];
    diff  = trial - {1'b0, b_q};
    if (!op_q[2])          acc_nx = {sum, acc_q[XLEN-1:1]};
    else if (diff[XLEN])   acc_nx = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                   acc_nx = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    prod = neg_q ? -acc_nx : acc_nx;
    quo  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem  = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    if (!op_q[2]) final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else          final_res = op_q[1] ? rem : quo;
    last = (cnt_q == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.funct3;
      neg_q <= neg_d;
      cnt_q <= '0;
      acc_q <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag1 : mag2)};
      b_q   <= bus.funct3[2] ? mag2 : mag1;
      if (special) result_q <= special_res;
    end else if ((state_q == StRun) && !bus.flush) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q + 1'b1;
      if (last) result_q <= final_res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = special ? StDone : StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.out_valid = (state_q == StDone);
    bus.result    = result_q;
  end

endmodule
